// File: rtl/cp0_exc_ctrl.sv
// Exception/interrupt sequencer in front of the CP0 register file.
// Serialises EPC/Cause/Status writes through the single CP0 write port, then
// pulses a PC redirect. Shadow Status/EPC copies avoid any CP0 read path.
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
    parameter logic [4:0]  REG_STATUS = 5'd12,
    parameter logic [4:0]  REG_CAUSE  = 5'd13,
    parameter logic [4:0]  REG_EPC    = 5'd14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        int_ok,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    input  logic        sw_w,
    input  logic [4:0]  sw_a,
    input  logic [31:0] sw_wd,
    output logic        cp0_w,
    output logic [4:0]  cp0_a,
    output logic [31:0] cp0_wd,
    output logic        busy,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    typedef enum logic [2:0] {
        StIdle,
        StWEpc,
        StWCause,
        StWStatus,
        StEStatus,
        StRedir
    } state_e;

    state_e      state_q, state_d;

    // Sequence latches captured at acceptance
    logic [31:0] pc_q;
    logic [4:0]  code_q;
    logic [5:0]  ip_q;
    logic        eret_q;

    // Shadow copies of Status and EPC
    logic [5:0]  im_q;
    logic        exl_q;
    logic        ie_q;
    logic [31:0] epc_q;

    logic        idle;
    logic        int_pend;
    logic        acc_exc;
    logic        acc_int;
    logic        acc_eret;
    logic        sw_pass;
    logic [31:0] status_set_exl;
    logic [31:0] status_clr_exl;
    logic [31:0] cause_val;

    assign idle     = (state_q == StIdle);
    assign int_pend = (|(hw_int & im_q)) & ie_q & ~exl_q & int_ok;
    assign acc_exc  = idle & exc_req;
    assign acc_int  = idle & ~exc_req & int_pend;
    assign acc_eret = idle & ~exc_req & ~int_pend & eret;
    // An accepted exception wins the write port over a same-cycle MTC0
    assign sw_pass  = idle & sw_w & ~exc_req;

    assign status_set_exl = {16'b0, im_q, 8'b0, 1'b1, ie_q};
    assign status_clr_exl = {16'b0, im_q, 8'b0, 1'b0, ie_q};
    assign cause_val      = {16'b0, ip_q, 3'b0, code_q, 2'b0};

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (acc_exc || acc_int) begin
                    state_d = StWEpc;
                end else if (acc_eret) begin
                    state_d = StEStatus;
                end
            end
            StWEpc:    state_d = StWCause;
            StWCause:  state_d = StWStatus;
            StWStatus: state_d = StRedir;
            StEStatus: state_d = StRedir;
            StRedir:   state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Capture faulting PC, code and pending lines at acceptance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q   <= 32'h0;
            code_q <= 5'h0;
            ip_q   <= 6'h0;
            eret_q <= 1'b0;
        end else if (idle) begin
            eret_q <= acc_eret;
            if (acc_exc || acc_int) begin
                pc_q   <= exc_pc;
                code_q <= exc_req ? exc_code : 5'h0;
                ip_q   <= hw_int;
            end
        end
    end

    // Shadow Status/EPC tracking of MTC0 traffic and sequence side effects
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q  <= 6'h3F;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            epc_q <= 32'h0;
        end else begin
            if (sw_pass && (sw_a == REG_STATUS)) begin
                im_q  <= sw_wd[15:10];
                exl_q <= sw_wd[1];
                ie_q  <= sw_wd[0];
            end
            if (sw_pass && (sw_a == REG_EPC)) begin
                epc_q <= sw_wd;
            end
            // Accepted exception/interrupt PC overrides a same-cycle MTC0 EPC
            if (acc_exc || acc_int) begin
                epc_q <= exc_pc;
            end
            if (state_q == StWStatus) begin
                exl_q <= 1'b1;
            end
            if (state_q == StEStatus) begin
                exl_q <= 1'b0;
            end
        end
    end

    // Output decode: MTC0 pass-through in idle, Moore writes otherwise
    always_comb begin
        cp0_w       = 1'b0;
        cp0_a       = 5'h0;
        cp0_wd      = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        busy        = 1'b1;
        unique case (state_q)
            StIdle: begin
                busy   = 1'b0;
                cp0_w  = sw_pass;
                cp0_a  = sw_a;
                cp0_wd = sw_wd;
            end
            StWEpc: begin
                cp0_w  = 1'b1;
                cp0_a  = REG_EPC;
                cp0_wd = pc_q;
            end
            StWCause: begin
                cp0_w  = 1'b1;
                cp0_a  = REG_CAUSE;
                cp0_wd = cause_val;
            end
            StWStatus: begin
                cp0_w  = 1'b1;
                cp0_a  = REG_STATUS;
                cp0_wd = status_set_exl;
            end
            StEStatus: begin
                cp0_w  = 1'b1;
                cp0_a  = REG_STATUS;
                cp0_wd = status_clr_exl;
            end
            StRedir: begin
                redirect    = 1'b1;
                redirect_pc = eret_q ? epc_q : EXC_VECTOR;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed scenarios plus random traffic
// compared against a transaction-level model of expected per-cycle port activity.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        int_ok;
    logic [5:0]  hw_int;
    logic        eret;
    logic        sw_w;
    logic [4:0]  sw_a;
    logic [31:0] sw_wd;
    logic        cp0_w;
    logic [4:0]  cp0_a;
    logic [31:0] cp0_wd;
    logic        busy;
    logic        redirect;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    cp0_exc_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .exc_req     (exc_req),
        .exc_code    (exc_code),
        .exc_pc      (exc_pc),
        .int_ok      (int_ok),
        .hw_int      (hw_int),
        .eret        (eret),
        .sw_w        (sw_w),
        .sw_a        (sw_a),
        .sw_wd       (sw_wd),
        .cp0_w       (cp0_w),
        .cp0_a       (cp0_a),
        .cp0_wd      (cp0_wd),
        .busy        (busy),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    // Expected port activity for one busy cycle
    typedef struct {
        logic        w;
        logic [4:0]  a;
        logic [31:0] wd;
        logic        rd;
        logic [31:0] rpc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Architectural model of shadow Status/EPC
    logic [5:0]  m_im;
    logic        m_exl;
    logic        m_ie;
    logic [31:0] m_epc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void push(input logic w, input logic [4:0] a, input logic [31:0] wd,
                                 input logic rd, input logic [31:0] rpc);
        exp_t x;
        x.w = w; x.a = a; x.wd = wd; x.rd = rd; x.rpc = rpc;
        exp_q.push_back(x);
    endfunction

    function automatic void model_reset();
        m_im  = 6'h3F;
        m_exl = 1'b0;
        m_ie  = 1'b0;
        m_epc = 32'h0;
        exp_q.delete();
    endfunction

    task automatic drive_idle();
        exc_req = 1'b0; exc_code = 5'h0; exc_pc = 32'h0; int_ok = 1'b0;
        hw_int = 6'h0; eret = 1'b0; sw_w = 1'b0; sw_a = 5'h0; sw_wd = 32'h0;
    endtask

    // One clock cycle: drive, compare against model, advance model
    task automatic step(input logic e, input logic [4:0] code, input logic [31:0] pc,
                        input logic iok, input logic [5:0] hw, input logic er,
                        input logic sw, input logic [4:0] sa, input logic [31:0] swd);
        exp_t  x;
        logic  was_idle;
        logic  pend;
        logic [4:0] ce;
        @(negedge clk);
        exc_req = e; exc_code = code; exc_pc = pc; int_ok = iok; hw_int = hw;
        eret = er; sw_w = sw; sw_a = sa; sw_wd = swd;
        #1;
        was_idle = (exp_q.size() == 0);
        if (was_idle) begin
            x.w = sw & ~e; x.a = sa; x.wd = swd; x.rd = 1'b0; x.rpc = 32'h0;
        end else begin
            x = exp_q.pop_front();
        end
        check("busy", 32'(busy), 32'(!was_idle));
        check("cp0_w", 32'(cp0_w), 32'(x.w));
        if (x.w) begin
            check("cp0_a", 32'(cp0_a), 32'(x.a));
            check("cp0_wd", cp0_wd, x.wd);
        end
        check("redirect", 32'(redirect), 32'(x.rd));
        if (x.rd) check("redirect_pc", redirect_pc, x.rpc);
        if (was_idle) begin
            pend = ((hw & m_im) != 6'h0) && m_ie && !m_exl && iok;
            if (sw && !e) begin
                if (sa == 5'd12) begin
                    m_im = swd[15:10]; m_exl = swd[1]; m_ie = swd[0];
                end
                if (sa == 5'd14) m_epc = swd;
            end
            if (e || pend) begin
                ce    = e ? code : 5'd0;
                m_epc = pc;
                push(1'b1, 5'd14, pc, 1'b0, 32'h0);
                push(1'b1, 5'd13, (32'(hw) << 10) | (32'(ce) << 2), 1'b0, 32'h0);
                push(1'b1, 5'd12, (32'(m_im) << 10) | 32'd2 | 32'(m_ie), 1'b0, 32'h0);
                push(1'b0, 5'd0, 32'h0, 1'b1, 32'h0000_0080);
                m_exl = 1'b1;
            end else if (er) begin
                push(1'b1, 5'd12, (32'(m_im) << 10) | 32'(m_ie), 1'b0, 32'h0);
                push(1'b0, 5'd0, 32'h0, 1'b1, m_epc);
                m_exl = 1'b0;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        drive_idle();
        reset = 1'b0;
        model_reset();
        #3;
        check("rst_cp0_w", 32'(cp0_w), 0);
        check("rst_cp0_a", 32'(cp0_a), 0);
        check("rst_cp0_wd", cp0_wd, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_redirect", 32'(redirect), 0);
        check("rst_redirect_pc", redirect_pc, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // First MTC0 Status passes through: IM bit0, IE=1
        step(0, 0, 0, 0, 0, 0, 1, 5'd12, 32'h0000_0401);
        // Exception code 12 at 0x1004
        step(1, 5'd12, 32'h0000_1004, 0, 0, 0, 0, 0, 0);
        idle_cycles(4);
        // ERET back to 0x1004
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle_cycles(2);
        // Interrupt on line 0
        step(0, 0, 32'h0000_2000, 1, 6'b000001, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0000_2004, 1, 6'b000001, 0, 0, 0, 0);
        // EXL=1 now: interrupt must not be taken
        step(0, 0, 32'h0000_2008, 1, 6'b000001, 0, 0, 0, 0);
        step(0, 0, 32'h0000_200C, 1, 6'b000001, 0, 0, 0, 0);
        // Nested exception with EXL=1 still overwrites EPC
        step(1, 5'd4, 32'h0000_3000, 0, 0, 0, 0, 0, 0);
        idle_cycles(4);
        // Simultaneous exc + eret + MTC0: exception sequence only
        step(1, 5'd8, 32'h0000_4000, 0, 0, 1, 1, 5'd14, 32'hDEAD_BEEF);
        idle_cycles(4);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle_cycles(2);

        // Reset pulse during W_CAUSE aborts the sequence
        step(1, 5'd12, 32'h0000_5000, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("wcause_w", 32'(cp0_w), 1);
        check("wcause_a", 32'(cp0_a), 13);
        reset = 1'b0;
        #1;
        check("abort_cp0_w", 32'(cp0_w), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_redirect", 32'(redirect), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_cycles(5);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] sa;
            case ($urandom_range(0, 3))
                0:       sa = 5'd12;
                1:       sa = 5'd14;
                2:       sa = 5'd13;
                default: sa = 5'($urandom);
            endcase
            step(($urandom_range(0, 9) == 0), 5'($urandom), $urandom & 32'hFFFF_FFFC,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h0,
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), sa, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
